data_ram: RTL and testbench

Parametrised single-port data memory for the MIPS datapath: the successor to the fixed 1024×32 word RAM. It adds configurable width and depth, byte-lane write enables, a programmable access latency, and a req/ready/ack handshake, so the pipeline can stall on slow memory. All storage updates and read data are synchronous to the rising clock edge.

---
 rtl/data_ram_pkg.sv | 15 +
 rtl/data_ram_array.sv | 37 +++
 rtl/data_ram.sv | 159 +++++++++++++++
 tb/tb_data_ram.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data_ram memory block.
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);
    localparam int STATS_W     = 32;

endpackage

// File: rtl/data_ram_array.sv
// Word storage with byte-lane write enables and a registered, read-enabled read port.
module data_ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W/8-1:0]      lane_we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    localparam int BE_W = DATA_W / 8;

    // Contents are deliberately left unreset so the array maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (lane_we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Output register holds between reads; its reset maps onto the RAM output-register reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_ram.sv
// Parametrised single-port data memory with req/ready/ack handshake and programmable latency.
// Optional access counters (rd_cnt, wr_cnt) are built when DATA_RAM_STATS_EN is defined.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     ready,
    output logic                     ack,
    output logic [DATA_W-1:0]        rdata
`ifdef DATA_RAM_STATS_EN
    ,
    output logic [STATS_W-1:0]       rd_cnt,
    output logic [STATS_W-1:0]       wr_cnt
`endif
);

    localparam int BE_W   = DATA_W / 8;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              accept;

    // Signals presented to the array on the edge that enters DONE.
    logic              mem_go;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   lane_we;
    logic              mem_re;

    assign ready  = (state_reg != BUSY);
    assign ack    = (state_reg == DONE);
    assign accept = req && ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= CNT_LOAD;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // At latency 1 the accepting edge is also the completing edge, so the live request drives the array.
    generate
        if (LATENCY == 1) begin : g_direct
            assign mem_go    = accept;
            assign mem_we    = we;
            assign mem_be    = be;
            assign mem_addr  = addr;
            assign mem_wdata = wdata;
        end else begin : g_captured
            logic              we_reg;
            logic [BE_W-1:0]   be_reg;
            logic [ADDR_W-1:0] addr_reg;
            logic [DATA_W-1:0] wdata_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    we_reg    <= 1'b0;
                    be_reg    <= '0;
                    addr_reg  <= '0;
                    wdata_reg <= '0;
                end else if (accept) begin
                    we_reg    <= we;
                    be_reg    <= be;
                    addr_reg  <= addr;
                    wdata_reg <= wdata;
                end
            end

            assign mem_go    = (state_reg == BUSY) && (cnt_reg == '0);
            assign mem_we    = we_reg;
            assign mem_be    = be_reg;
            assign mem_addr  = addr_reg;
            assign mem_wdata = wdata_reg;
        end
    endgenerate

    // Reset wins over a completing access so a dropped request never touches memory.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            assign lane_we[gi] = rst_n && mem_go && mem_we && mem_be[gi];
        end
    endgenerate

    assign mem_re = mem_go && !mem_we;

    data_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .lane_we (lane_we),
        .re      (mem_re),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata   (rdata)
    );

`ifdef DATA_RAM_STATS_EN
    logic [STATS_W-1:0] rd_cnt_reg;
    logic [STATS_W-1:0] wr_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else begin
            if (mem_go && !mem_we && (rd_cnt_reg != '1)) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
            if (mem_go && mem_we && (wr_cnt_reg != '1)) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
        end
    end

    assign rd_cnt = rd_cnt_reg;
    assign wr_cnt = wr_cnt_reg;
`endif

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: three instances at latencies 1, 4 and 3 against a word-array model.
module tb_data_ram;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int BW  = 4;
    localparam int NI  = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    bit clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req   [NI];
    logic          we    [NI];
    logic [BW-1:0] be    [NI];
    logic [AW-1:0] addr  [NI];
    logic [DW-1:0] wdata [NI];
    logic          ready [NI];
    logic          ack   [NI];
    logic [DW-1:0] rdata [NI];
    logic [31:0]   rd_cnt [NI];
    logic [31:0]   wr_cnt [NI];

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            data_ram #(
                .DATA_W  (DW),
                .DEPTH   (DEP),
                .LATENCY (lat_of(gi))
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .req   (req[gi]),
                .we    (we[gi]),
                .be    (be[gi]),
                .addr  (addr[gi]),
                .wdata (wdata[gi]),
                .ready (ready[gi]),
                .ack   (ack[gi]),
                .rdata (rdata[gi])
`ifdef DATA_RAM_STATS_EN
                ,
                .rd_cnt (rd_cnt[gi]),
                .wr_cnt (wr_cnt[gi])
`endif
            );
`ifndef DATA_RAM_STATS_EN
            assign rd_cnt[gi] = '0;
            assign wr_cnt[gi] = '0;
`endif
        end
    endgenerate

    // Reference model: plain word array per instance plus completed-access counts since reset.
    logic [DW-1:0] mem_m   [NI][DEP];
    logic [DW-1:0] last_rd [NI];
    int            rd_n    [NI];
    int            wr_n    [NI];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_write(input int k, input logic [BW-1:0] b, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < BW; i++) begin
            if (b[i]) mask[8*i +: 8] = 8'hFF;
        end
        mem_m[k][a] = (mem_m[k][a] & ~mask) | (d & mask);
        wr_n[k]++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            last_rd[k] = '0;
            rd_n[k]    = 0;
            wr_n[k]    = 0;
        end
    endtask

    // One complete access: present, wait for ready, then follow the ack timing for this latency.
    task automatic transact(input int k, input logic w, input logic [BW-1:0] b,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t;
        int lat;
        lat = lat_of(k);
        @(negedge clk);
        check($sformatf("ack_pulse_i%0d", k), ack[k], 1'b0);
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        t = 0;
        while (ready[k] !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("ready_wait_i%0d", k), ready[k], 1'b1);
        @(negedge clk);
        req[k] = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("ack_i%0d_c%0d", k, c), ack[k], (c == lat));
            if (c < lat) check($sformatf("busy_ready_i%0d", k), ready[k], 1'b0);
        end
        check($sformatf("done_ready_i%0d", k), ready[k], 1'b1);
        if (w) begin
            model_write(k, b, a, d);
            check($sformatf("wr_rdata_hold_i%0d", k), rdata[k], last_rd[k]);
        end else begin
            last_rd[k] = mem_m[k][a];
            rd_n[k]++;
            check($sformatf("rd_data_i%0d_a%0d", k, a), rdata[k], last_rd[k]);
        end
        $display("txn inst=%0d lat=%0d %s addr=%0d be=%h wdata=%h rdata=%h", k, lat,
                 w ? "WR" : "RD", a, b, d, rdata[k]);
    endtask

    task automatic check_stats(input string tag);
`ifdef DATA_RAM_STATS_EN
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_rd_cnt_i%0d", tag, k), rd_cnt[k], rd_n[k]);
            check($sformatf("%s_wr_cnt_i%0d", tag, k), wr_cnt[k], wr_n[k]);
        end
`else
        $display("stats %s: counters not built", tag);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_ready_i%0d", tag, k), ready[k], 1'b1);
            check($sformatf("%s_ack_i%0d", tag, k), ack[k], 1'b0);
            check($sformatf("%s_rdata_i%0d", tag, k), rdata[k], '0);
        end
        check_stats(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; be[k] = '0; addr[k] = '0; wdata[k] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("reset");

        // Preload every word so later reads never see uninitialised contents.
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < DEP; a++) begin
                transact(k, 1'b1, 4'hF, AW'(a), $urandom);
            end
        end

        // Random mix of reads and partial writes.
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 24; n++) begin
                transact(k, 1'($urandom_range(0, 1)), BW'($urandom), AW'($urandom), $urandom);
            end
        end

        // Full-word write then byte-lane merge at latency 1.
        transact(0, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
        transact(0, 1'b0, 4'h0, 4'd5, 32'h0);
        check("full_word_read", rdata[0], 32'hDEADBEEF);
        transact(0, 1'b1, 4'b0101, 4'd5, 32'h11223344);
        transact(0, 1'b0, 4'h0, 4'd5, 32'h0);
        check("byte_lane_merge", rdata[0], 32'hDE22BE44);
        transact(0, 1'b1, 4'b0000, 4'd5, 32'hFFFFFFFF);
        transact(0, 1'b0, 4'h0, 4'd5, 32'h0);
        check("be_zero_write", rdata[0], 32'hDE22BE44);

        // Back-to-back reads at latency 1 with req held high.
        for (int i = 0; i < 8; i++) transact(0, 1'b1, 4'hF, AW'(i), 32'h100 + i);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; be[0] = '0; addr[0] = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_ack_%0d", i), ack[0], 1'b1);
            check($sformatf("b2b_rdata_%0d", i), rdata[0], 32'h100 + i);
            $display("txn inst=0 lat=1 RD b2b addr=%0d rdata=%h", i, rdata[0]);
            if (i < 7) addr[0] = AW'(i + 1);
            else req[0] = 1'b0;
        end
        last_rd[0] = 32'h107;
        rd_n[0] += 8;

        // Latency 4: second read held through BUSY is taken on the ack edge.
        @(negedge clk);
        check("l4_idle_ready", ready[1], 1'b1);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = '0; addr[1] = 4'd3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) addr[1] = 4'd7;
            if (c == 5) req[1] = 1'b0;
            check($sformatf("l4_ack_c%0d", c), ack[1], (c == 4 || c == 8));
            check($sformatf("l4_ready_c%0d", c), ready[1], (c == 4 || c == 8));
            if (c == 4) check("l4_rdata_first", rdata[1], mem_m[1][3]);
            if (c == 8) check("l4_rdata_second", rdata[1], mem_m[1][7]);
        end
        $display("txn inst=1 lat=4 RD addr=3 then addr=7 rdata=%h", rdata[1]);
        last_rd[1] = mem_m[1][7];
        rd_n[1] += 2;

        check_stats("pre_reset");

        // Reset one edge after accepting a write at latency 3 must drop it.
        @(negedge clk);
        check("rst_mid_ready", ready[2], 1'b1);
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 4'd9; wdata[2] = 32'hCAFEF00D;
        @(negedge clk);
        req[2] = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_state("mid_reset");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst_no_ack_%0d", c), ack[2], 1'b0);
        end
        $display("txn inst=2 lat=3 WR addr=9 dropped by reset");
        transact(2, 1'b0, 4'h0, 4'd9, 32'h0);
        check_stats("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
